// File: rtl/fubar2_arbiter.sv
// Round-robin issue arbiter in front of a fixed-latency fubar2 unit.
// Winners are registered to the unit, and each result returns as a response tagged with the requester id.
module fubar2_arbiter #(
   parameter int NREQ = 4,
   parameter int LAT  = 2
) (
   input  logic                    clk,
   input  logic                    reset_l,
   input  logic                    arb_en,
   input  logic [NREQ-1:0]         req_i,
   input  logic [2*NREQ-1:0]       req_data_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [1:0]              an_input2,
   output logic                    unit_valid,
   input  logic [1:0]              another_output2,
   output logic                    rsp_valid,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [1:0]              rsp_data,
   output logic                    busy
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = IDW + 1;

   // Handshake: a requester holds req_i[k] and its operand until it sees
   // gnt_o[k] for one cycle, then drops req_i[k] in the following cycle
   // unless it has a new request; gnt_o masks k during the grant cycle.
   // Responses are never back-pressured.

   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            unit_valid_q, unit_valid_d;
   logic [1:0]      an_input2_q, an_input2_d;
   logic [IDW-1:0]  issue_id_q, issue_id_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [LAT-1:0]  tag_v_q, tag_v_d;
   logic [IDW-1:0]  tag_id_q [LAT];
   logic [IDW-1:0]  tag_id_d [LAT];
   logic            rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [1:0]      rsp_data_q, rsp_data_d;

   logic [NREQ-1:0] elig;
   logic            found;
   logic [IDW-1:0]  win;
   logic [CW-1:0]   cand;

   // Search upward from ptr, wrapping at NREQ-1; the first eligible index wins.
   always_comb begin
      elig  = req_i & ~gnt_q & {NREQ{arb_en}};
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr_q} + CW'(i);
         if (cand >= CW'(NREQ)) begin
            cand = cand - CW'(NREQ);
         end
         if (!found && elig[cand[IDW-1:0]]) begin
            found = 1'b1;
            win   = cand[IDW-1:0];
         end
      end
   end

   always_comb begin
      gnt_d        = '0;
      unit_valid_d = found;
      an_input2_d  = an_input2_q;
      issue_id_d   = issue_id_q;
      ptr_d        = ptr_q;
      if (found) begin
         gnt_d[win]  = 1'b1;
         an_input2_d = req_data_i[{win, 1'b0} +: 2];
         issue_id_d  = win;
         ptr_d       = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
      end
   end

   // Stage i holds the issue that was on the unit i+1 cycles ago, so the
   // last stage lines up with the cycle the unit result is valid.
   always_comb begin
      tag_v_d[0]  = unit_valid_q;
      tag_id_d[0] = issue_id_q;
      for (int i = 1; i < LAT; i++) begin
         tag_v_d[i]  = tag_v_q[i-1];
         tag_id_d[i] = tag_id_q[i-1];
      end
   end

   always_comb begin
      rsp_valid_d = tag_v_q[LAT-1];
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      if (tag_v_q[LAT-1]) begin
         rsp_id_d   = tag_id_q[LAT-1];
         rsp_data_d = another_output2;
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         gnt_q        <= '0;
         unit_valid_q <= 1'b0;
         an_input2_q  <= '0;
         issue_id_q   <= '0;
         ptr_q        <= '0;
         tag_v_q      <= '0;
         for (int i = 0; i < LAT; i++) begin
            tag_id_q[i] <= '0;
         end
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
      end else begin
         gnt_q        <= gnt_d;
         unit_valid_q <= unit_valid_d;
         an_input2_q  <= an_input2_d;
         issue_id_q   <= issue_id_d;
         ptr_q        <= ptr_d;
         tag_v_q      <= tag_v_d;
         for (int i = 0; i < LAT; i++) begin
            tag_id_q[i] <= tag_id_d[i];
         end
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   assign gnt_o      = gnt_q;
   assign unit_valid = unit_valid_q;
   assign an_input2  = an_input2_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;
   assign busy       = unit_valid_q | (|tag_v_q) | rsp_valid_q;

endmodule

// File: tb/tb_fubar2_arbiter.sv
// Bench for fubar2_arbiter: directed scenarios with literal expectations,
// plus a queue-based reference model compared on every falling edge.
module tb_fubar2_arbiter;

   localparam int NREQ = 4;
   localparam int LAT  = 2;
   localparam int IDW  = $clog2(NREQ);
   localparam int EW   = 32 + IDW + 2;

   logic                  clk = 1'b0;
   logic                  reset_l = 1'b0;
   logic                  arb_en = 1'b0;
   logic [NREQ-1:0]       req_i = '0;
   logic [2*NREQ-1:0]     req_data_i = '0;
   logic [1:0]            another_output2 = '0;
   logic [NREQ-1:0]       gnt_o;
   logic [1:0]            an_input2;
   logic                  unit_valid;
   logic                  rsp_valid;
   logic [IDW-1:0]        rsp_id;
   logic [1:0]            rsp_data;
   logic                  busy;

   int n_checks = 0;
   int n_fail   = 0;

   fubar2_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
      .clk             (clk),
      .reset_l         (reset_l),
      .arb_en          (arb_en),
      .req_i           (req_i),
      .req_data_i      (req_data_i),
      .gnt_o           (gnt_o),
      .an_input2       (an_input2),
      .unit_valid      (unit_valid),
      .another_output2 (another_output2),
      .rsp_valid       (rsp_valid),
      .rsp_id          (rsp_id),
      .rsp_data        (rsp_data),
      .busy            (busy)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected end of directed sequence");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Unit stand-in: result = operand + 2, presented exactly LAT cycles after
   // unit_valid; every other cycle carries random filler.
   logic [1:0] unit_res [16];
   int         cyc = 0;

   initial begin
      for (int i = 0; i < 16; i++) unit_res[i] = 2'($urandom_range(0, 3));
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (unit_valid) unit_res[(cyc + LAT) % 16] = an_input2 + 2'd2;
   end

   always @(posedge clk) begin
      #1;
      another_output2 = unit_res[cyc % 16];
      unit_res[cyc % 16] = 2'($urandom_range(0, 3));
   end

   // Reference model: pending responses are kept as {due_cycle, id, data}.
   int              m_ptr = 0;
   int              m_now = 0;
   int              m_win;
   bit              m_found;
   logic [NREQ-1:0] m_gnt = '0;
   logic            m_uv = 1'b0;
   logic [1:0]      m_in2 = '0;
   logic            m_rv = 1'b0;
   logic [IDW-1:0]  m_rid = '0;
   logic [1:0]      m_rdata = '0;
   logic            m_busy = 1'b0;
   logic [EW-1:0]   exp_q[$];

   always @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         m_ptr = 0; m_now = 0; m_gnt = '0; m_uv = 1'b0; m_in2 = '0;
         m_rv = 1'b0; m_rid = '0; m_rdata = '0;
         exp_q.delete();
      end else begin
         m_now++;
         m_found = 1'b0;
         m_win = 0;
         for (int s = 0; s < NREQ; s++) begin
            if (!m_found && arb_en && req_i[(m_ptr + s) % NREQ] && !m_gnt[(m_ptr + s) % NREQ]) begin
               m_found = 1'b1;
               m_win = (m_ptr + s) % NREQ;
            end
         end
         m_gnt = '0;
         m_uv = m_found;
         if (m_found) begin
            m_gnt[m_win] = 1'b1;
            m_in2 = req_data_i[2*m_win +: 2];
            m_ptr = (m_win + 1) % NREQ;
            exp_q.push_back({32'(m_now + LAT + 1), IDW'(m_win), 2'(req_data_i[2*m_win +: 2] + 2'd2)});
         end
         m_rv = 1'b0;
         if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == m_now) begin
            m_rv = 1'b1;
            m_rid = exp_q[0][IDW+1:2];
            m_rdata = exp_q[0][1:0];
            void'(exp_q.pop_front());
         end
      end
      m_busy = (exp_q.size() > 0) || m_rv;
   end

   // Scoreboard compare on every falling edge
   always @(negedge clk) begin
      chk("sb_gnt_o", gnt_o, m_gnt);
      chk("sb_unit_valid", unit_valid, m_uv);
      chk("sb_an_input2", an_input2, m_in2);
      chk("sb_rsp_valid", rsp_valid, m_rv);
      chk("sb_rsp_id", rsp_id, m_rid);
      chk("sb_rsp_data", rsp_data, m_rdata);
      chk("sb_busy", busy, m_busy);
   end

   // Driver: apply one cycle of inputs just after the rising edge
   task automatic cyc_in(input logic [NREQ-1:0] r, input logic [2*NREQ-1:0] d, input logic en);
      @(posedge clk);
      #1;
      req_i = r;
      req_data_i = d;
      arb_en = en;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cyc_in('0, '0, 1'b1);
   endtask

   int rsp_seen;

   initial begin
      arb_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", gnt_o, 0);
      chk("rst_uv", unit_valid, 0);
      chk("rst_in2", an_input2, 0);
      chk("rst_rv", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      #2 reset_l = 1'b1;

      // Single request to id 2
      cyc_in(4'b0100, 8'b0011_0000, 1'b1);
      chk("t1_c0_gnt", gnt_o, 0);
      cyc_in(4'b0100, 8'b0011_0000, 1'b1);
      chk("t1_c1_gnt", gnt_o, 4'b0100);
      chk("t1_c1_uv", unit_valid, 1);
      chk("t1_c1_in2", an_input2, 2'b11);
      chk("t1_c1_busy", busy, 1);
      cyc_in(4'b0000, 8'b0, 1'b1);
      chk("t1_c2_gnt", gnt_o, 0);
      chk("t1_c2_in2_hold", an_input2, 2'b11);
      cyc_in(4'b0000, 8'b0, 1'b1);
      cyc_in(4'b0000, 8'b0, 1'b1);
      chk("t1_c4_rv", rsp_valid, 1);
      chk("t1_c4_id", rsp_id, 2);
      chk("t1_c4_data", rsp_data, 2'b01);
      cyc_in(4'b0000, 8'b0, 1'b1);
      chk("t1_c5_rv", rsp_valid, 0);
      chk("t1_c5_data_hold", rsp_data, 2'b01);
      chk("t1_c5_busy", busy, 0);

      // All four requesting continuously from reset
      reset_l = 1'b0;
      repeat (2) @(posedge clk);
      #3 reset_l = 1'b1;
      cyc_in(4'b1111, 8'b11_10_01_00, 1'b1);
      chk("t2_c0_gnt", gnt_o, 0);
      cyc_in(4'b1111, 8'b11_10_01_00, 1'b1);
      chk("t2_c1_gnt", gnt_o, 4'b0001);
      cyc_in(4'b1111, 8'b11_10_01_00, 1'b1);
      chk("t2_c2_gnt", gnt_o, 4'b0010);
      cyc_in(4'b1111, 8'b11_10_01_00, 1'b1);
      chk("t2_c3_gnt", gnt_o, 4'b0100);
      cyc_in(4'b1111, 8'b11_10_01_00, 1'b1);
      chk("t2_c4_gnt", gnt_o, 4'b1000);
      chk("t2_c4_rid", rsp_id, 0);
      chk("t2_c4_rdata", rsp_data, 2'b10);
      cyc_in(4'b0000, 8'b11_10_01_00, 1'b1);
      chk("t2_c5_gnt", gnt_o, 4'b0001);
      chk("t2_c5_rid", rsp_id, 1);
      chk("t2_c5_rdata", rsp_data, 2'b11);
      drain(6);

      // Wrap-around from ptr=3, no double grant while req_i[3] is held
      cyc_in(4'b0100, 8'b10_01_11_00, 1'b1);
      cyc_in(4'b0100, 8'b10_01_11_00, 1'b1);
      chk("t3_setup_gnt", gnt_o, 4'b0100);
      cyc_in(4'b0000, 8'b10_01_11_00, 1'b1);
      cyc_in(4'b0000, 8'b10_01_11_00, 1'b1);
      cyc_in(4'b1001, 8'b10_01_11_00, 1'b1);
      cyc_in(4'b1001, 8'b10_01_11_00, 1'b1);
      chk("t3_gnt3", gnt_o, 4'b1000);
      chk("t3_in2_3", an_input2, 2'b10);
      cyc_in(4'b0001, 8'b10_01_11_00, 1'b1);
      chk("t3_gnt0", gnt_o, 4'b0001);
      chk("t3_in2_0", an_input2, 2'b00);
      cyc_in(4'b0000, 8'b10_01_11_00, 1'b1);
      chk("t3_no_regrant", gnt_o, 0);
      drain(5);

      // arb_en low with two issues in flight
      cyc_in(4'b0011, 8'b00_00_01_10, 1'b1);
      cyc_in(4'b0011, 8'b00_00_01_10, 1'b1);
      chk("t4_gnt1", gnt_o, 4'b0010);
      cyc_in(4'b1111, 8'b00_00_01_10, 1'b0);
      chk("t4_gnt0", gnt_o, 4'b0001);
      rsp_seen = 0;
      for (int i = 0; i < 6; i++) begin
         cyc_in(4'b1111, 8'b00_00_01_10, 1'b0);
         chk("t4_hold_gnt", gnt_o, 0);
         chk("t4_busy", busy, (i <= 2) ? 1 : 0);
         if (rsp_valid) rsp_seen++;
      end
      chk("t4_rsp_count", rsp_seen, 2);
      cyc_in(4'b1111, 8'b00_00_01_10, 1'b1);
      cyc_in(4'b1111, 8'b00_00_01_10, 1'b1);
      chk("t4_resume_gnt", gnt_o, 4'b0010);
      cyc_in(4'b1101, 8'b00_00_01_10, 1'b1);
      chk("t4_next_gnt", gnt_o, 4'b0100);
      cyc_in(4'b1001, 8'b00_00_01_10, 1'b1);
      cyc_in(4'b0001, 8'b00_00_01_10, 1'b1);
      cyc_in(4'b0000, 8'b00_00_01_10, 1'b1);
      drain(5);

      // Reset with three issues in flight
      cyc_in(4'b0111, 8'b00_11_01_10, 1'b1);
      cyc_in(4'b0111, 8'b00_11_01_10, 1'b1);
      chk("t5_gnt1", gnt_o, 4'b0010);
      cyc_in(4'b0101, 8'b00_11_01_10, 1'b1);
      chk("t5_gnt2", gnt_o, 4'b0100);
      cyc_in(4'b0001, 8'b00_11_01_10, 1'b1);
      chk("t5_gnt0", gnt_o, 4'b0001);
      #1;
      reset_l = 1'b0;
      req_i = '0;
      #1;
      chk("t5_rst_gnt", gnt_o, 0);
      chk("t5_rst_uv", unit_valid, 0);
      chk("t5_rst_in2", an_input2, 0);
      chk("t5_rst_rv", rsp_valid, 0);
      chk("t5_rst_id", rsp_id, 0);
      chk("t5_rst_data", rsp_data, 0);
      chk("t5_rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #3 reset_l = 1'b1;
      cyc_in(4'b0011, 8'b00_11_01_10, 1'b1);
      chk("t5_f0_rv", rsp_valid, 0);
      cyc_in(4'b0011, 8'b00_11_01_10, 1'b1);
      chk("t5_f1_gnt", gnt_o, 4'b0001);
      chk("t5_f1_rv", rsp_valid, 0);
      cyc_in(4'b0010, 8'b00_11_01_10, 1'b1);
      chk("t5_f2_gnt", gnt_o, 4'b0010);
      chk("t5_f2_rv", rsp_valid, 0);
      cyc_in(4'b0000, 8'b00_11_01_10, 1'b1);
      chk("t5_f3_rv", rsp_valid, 0);
      cyc_in(4'b0000, 8'b00_11_01_10, 1'b1);
      chk("t5_f4_rv", rsp_valid, 1);
      chk("t5_f4_id", rsp_id, 0);
      chk("t5_f4_data", rsp_data, 2'b00);
      cyc_in(4'b0000, 8'b00_11_01_10, 1'b1);
      chk("t5_f5_id", rsp_id, 1);
      chk("t5_f5_data", rsp_data, 2'b11);
      drain(4);
      chk("end_busy", busy, 0);

      // Final report
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fubar2_arbiter.md
FUBAR2_ARBITER -- requirements
Module: fubar2_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter LAT, default 2, giving the fixed fubar2 unit latency in cycles (1..4).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  clock; all flops rising-edge.
- reset_l  in  1  asynchronous active-low reset.
- arb_en  in  1  allows new grants when 1.
- req_i  in  NREQ  per-requester request, level.
- req_data_i  in  2*NREQ  operands; requester k at bits [2k+1:2k].
- gnt_o  out  NREQ  one-hot grant pulse, registered.
- an_input2  out  2  operand to fubar2 unit, registered.
- unit_valid  out  1  an_input2 valid this cycle.
- another_output2  in  2  unit result, valid exactly LAT cycles after unit_valid.
- rsp_valid  out  1  response pulse.
- rsp_id  out  clog2(NREQ)  requester index of response.
- rsp_data  out  2  result for rsp_id.
- busy  out  1  issue or result in flight.

Function
REQ-005 Arbitration SHALL be round-robin over eligible requesters, searching upward from pointer ptr and wrapping at NREQ-1 to 0.
REQ-006 A requester k SHALL be eligible when req_i[k]=1, arb_en=1, and gnt_o[k]=0 in the same cycle; the gnt_o[k] mask prevents a double grant while the requester drops req_i.
REQ-007 When requester k wins in cycle T, then in cycle T+1 the block SHALL assert gnt_o[k], unit_valid=1, and an_input2=req_data_i[2k+1:2k] as sampled in T.
REQ-008 After a win by k, ptr SHALL become (k+1) mod NREQ; with no winner, ptr SHALL hold.
REQ-009 At most one grant SHALL issue per cycle; with continuous requests, throughput SHALL be one issue per cycle.
REQ-010 The protocol SHALL require requesters to hold req_i and data until gnt_o, and to deassert req_i in the cycle after gnt_o unless issuing a new request.
REQ-011 A LAT-deep tag pipeline SHALL track (valid, id) for each issue.
  - For an issue with unit_valid in cycle U, another_output2 SHALL be sampled at the end of U+LAT.
  - In cycle U+LAT+1 the block SHALL drive rsp_valid=1, rsp_id=id, and rsp_data=that sample.
REQ-012 Responses SHALL return in issue order; rsp_valid SHALL be a single-cycle pulse per issue and SHALL never be back-pressured.
REQ-013 With arb_en=0, no new grant SHALL issue; in-flight tags SHALL complete normally; ptr SHALL hold.
REQ-014 When arb_en rises, arbitration SHALL resume from the held ptr in the same cycle.
REQ-015 busy SHALL equal unit_valid OR any valid tag stage OR rsp_valid.
REQ-016 When gnt_o, unit_valid and rsp_valid are all 0, an_input2, rsp_id and rsp_data SHALL hold their last values.
REQ-017 A request asserted in the same cycle as a response for the same requester SHALL be arbitrated normally; issue and response paths are independent.

Reset
REQ-018 While reset_l=0, gnt_o, unit_valid, an_input2, rsp_valid, rsp_id, rsp_data, busy, ptr and all tag stages SHALL be 0.
REQ-019 On reset assertion mid-operation, all in-flight issues SHALL be dropped, with no rsp_valid produced for them.
REQ-020 On the first rising edge of clk after reset_l deasserts, the block SHALL arbitrate from ptr=0.

Verification
REQ-021 Single request, NREQ=4, LAT=2: req_i=0100, data[5:4]=2'b11 in cycle 0 -> gnt_o=0100, unit_valid=1, an_input2=11 in cycle 1; unit returns 01 in cycle 3 -> rsp_valid=1, rsp_id=2, rsp_data=01 in cycle 4.
REQ-022 All four requesting continuously from reset -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; responses in that id order, LAT+1 cycles after each grant.
REQ-023 ptr=3, req_i=1001 -> grant to id 3, then to id 0 (wrap-around); no double grant to 3 while req_i[3] is held one extra cycle.
REQ-024 arb_en=0 with req_i=1111 and two issues in flight -> no gnt_o; exactly two rsp_valid pulses; busy drops to 0 after the last; arb_en=1 resumes at the held ptr.
REQ-025 reset_l pulsed low while three issues are in flight -> all outputs 0 immediately; no rsp_valid after release; first grant goes to the lowest requesting index from ptr=0.
